pipeline_skid_reg: RTL
======================

// Module: pipeline_skid_reg
// PURPOSE
//  Next-generation MIPS inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries an N-bit bundle with a valid/ready handshake, stall (back-pressure),
//  synchronous flush (bubble insertion) and an optional 2-entry skid buffer.
//  With the skid buffer, in_ready is registered, so stage-to-stage timing paths are cut.
// PARAMETERS
//  N       32   payload width in bits
//  BUBBLE  0    N-bit value driven on out_data whenever out_valid=0 (NOP encoding)
//  SKID    1    1 = 2-entry skid buffer, registered in_ready; 0 = single register, combinational in_ready
// PORTS
//  clk        in   1   clock; all state updates on the falling edge
//  reset      in   1   reset, synchronous, active-high
//  flush      in   1   synchronous flush: discard all held data, insert bubble
//  in_valid   in   1   upstream offers in_data
//  in_ready   out  1   block accepts in_data this cycle
//  in_data    in   N   payload from the upstream stage
//  out_valid  out  1   out_data holds a live entry
//  out_ready  in   1   downstream consumes out_data this cycle
//  out_data   out  N   payload to the downstream stage
//  occupancy  out  2   number of held entries (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=BUBBLE, occupancy=0, state EMPTY, skid cleared.
//   in_ready=1 after reset (SKID=1). Reset overrides flush and all handshakes.
//  Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready, sampled at the falling edge.
//  Latency: 1 edge from accept to out_valid when empty. Strict FIFO order; no drop or duplicate except on flush.
//  out_data and out_valid are stable while out_valid=1 and out_ready=0.
//  out_data = BUBBLE in every cycle with out_valid=0. The payload register is cleared to BUBBLE on the drain of the last entry.
//  SKID=1 state machine (main register M, skid register S):
//   EMPTY: in_ready=1. accept -> ONE (M<=in_data).
//   ONE:   in_ready=1. accept & drain -> ONE (M<=in_data).
//          accept & !drain -> FULL (S<=in_data).
//          drain only -> EMPTY (M<=BUBBLE). Otherwise hold.
//   FULL:  in_ready=0. drain -> ONE (M<=S, S cleared). Otherwise hold.
//   in_ready is a decoded register output (!FULL). It has no combinational path from out_ready.
//  SKID=0: in_ready = !flush & (out_ready | !out_valid).
//   accept loads M and sets out_valid=1. Drain without accept clears out_valid and sets M<=BUBBLE.
//  Flush (highest priority below reset): on the edge, go to EMPTY, out_valid=0, M=S=BUBBLE, occupancy=0.
//   in_ready is forced to 0 combinationally while flush=1, so no input is accepted on a flush edge.
//   A drain in the same cycle as a flush is still counted by downstream; the entry is not replayed.
//  occupancy: EMPTY=0, ONE=1, FULL=2. It is updated on the same edge as the state.
//  Illegal state encoding (2'd3) recovers to EMPTY on the next edge.
// STRUCTURE
//  Shared package pipeline_pkg:
//   - state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
//   - DEFAULT_BUBBLE constant, used by all stage registers
//  One sub-module pipe_data_reg #(N,BUBBLE): negedge N-bit register with load, clear and sync reset.
//   It is instantiated for M and, under generate SKID=1, for S.
//  Control FSM and the in_ready/occupancy decode live in the top module.
// TESTING
//  1 Reset held 2 cycles -> out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1.
//  2 Stream 0x11,0x22,0x33 with out_ready=1 -> each appears 1 edge later, in order. Occupancy stays 1.
//  3 out_ready=0, offer 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted. in_ready=0 after the 2nd edge, 0xA3 is held upstream.
//    Release out_ready -> outputs A1,A2,A3 with no loss.
//  4 FULL (0xB1,0xB2) with flush=1 for one edge -> out_valid=0, out_data=BUBBLE, occupancy=0.
//    0xB2 never appears. in_ready=0 during flush, 1 on the next cycle.
//  5 SKID=0 build: out_ready toggling 1,0,1 with continuous in_valid -> in_ready tracks out_ready in the same cycle.
//    No data lost or duplicated.
//  6 Reset asserted while in FULL with in_valid=1 -> next edge all outputs at reset values. No data accepted.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers:
// state encodings, the default NOP bubble and the occupancy decode.
package pipeline_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [31:0] DEFAULT_BUBBLE = 32'h0000_0000;

    // 2'd3 is unreachable and reports as empty so out_valid and occupancy agree
    function automatic logic [1:0] state_occupancy(input logic [1:0] st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Falling-edge N-bit payload register with load, clear-to-bubble and sync reset.
// Reset and clear both return the register to the bubble value.
module pipe_data_reg
    import pipeline_pkg::*;
#(
    parameter int             N      = 32,
    parameter logic [N-1:0]   BUBBLE = N'(DEFAULT_BUBBLE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] data_d;
    logic [N-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = BUBBLE;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            data_q <= BUBBLE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipeline_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional 2-entry skid buffer (main register M, skid register S).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// EMPTY    | nothing held, out_valid=0, M and S hold the bubble
// ONE      | M holds the head entry, S is empty
// FULL     | M holds the head, S holds the next entry, in_ready=0
module pipeline_skid_reg
    import pipeline_pkg::*;
#(
    parameter int             N      = 32,
    parameter logic [N-1:0]   BUBBLE = N'(DEFAULT_BUBBLE),
    parameter bit             SKID   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [1:0]   state_d;
    logic [1:0]   state_q;
    logic         accept;
    logic         drain;
    logic         m_load;
    logic         m_clear;
    logic         m_from_s;
    logic         s_load;
    logic         s_clear;
    logic [N-1:0] m_in;
    logic [N-1:0] m_q;
    logic [N-1:0] s_q;

    assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign out_data  = out_valid ? m_q : BUBBLE;
    assign occupancy = state_occupancy(state_q);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign m_in      = m_from_s ? s_q : in_data;

    generate
        if (SKID) begin : g_skid
            // Decoded from the state flop only, so out_ready never reaches in_ready
            assign in_ready = !flush && ((state_q == ST_EMPTY) || (state_q == ST_ONE));

            pipe_data_reg #(.N(N), .BUBBLE(BUBBLE)) u_s_reg (
                .clk   (clk),
                .reset (reset),
                .load  (s_load),
                .clear (s_clear),
                .d     (in_data),
                .q     (s_q)
            );
        end else begin : g_noskid
            assign in_ready = !flush && (out_ready || !out_valid);
            assign s_q      = BUBBLE;
        end
    endgenerate

    pipe_data_reg #(.N(N), .BUBBLE(BUBBLE)) u_m_reg (
        .clk   (clk),
        .reset (reset),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_in),
        .q     (m_q)
    );

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_clear  = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        m_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        m_load = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        s_load  = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        m_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d  = ST_ONE;
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_clear  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
